// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues RV32I loads/stores on a simple req/ack
// bus, steers store lanes, extends load data and flags misaligned, illegal and
// timed-out accesses. Start/finish follow the enabled/completed pulse handshake.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TIMER_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    output logic        completed,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] result_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic [31:0] result_out,
    output logic [4:0]  rd_out,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    localparam logic [2:0] F3Byte   = 3'b000;
    localparam logic [2:0] F3Half   = 3'b001;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3ByteU  = 3'b100;
    localparam logic [2:0] F3HalfU  = 3'b101;

    // Last timer value before the request is abandoned (unused when disabled).
    localparam logic [TIMER_WIDTH-1:0] TimerLast =
        TIMER_WIDTH'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
    localparam bit TimeoutEn = (ACK_TIMEOUT != 0);

    state_e                 state_q, state_d;
    logic                   completed_q, completed_d;
    logic [31:0]            result_q, result_d;
    logic [4:0]             rd_q, rd_d;
    logic                   misaligned_q, misaligned_d;
    logic                   illegal_q, illegal_d;
    logic                   bus_error_q, bus_error_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic [3:0]             mem_wstrb_q, mem_wstrb_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic                   is_load_q, is_load_d;

    logic        is_mem;
    logic        do_store;
    logic        f3_legal;
    logic        addr_misaligned;
    logic [31:0] wdata_steer;
    logic [3:0]  wstrb_steer;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;

    assign is_mem   = is_load | is_store;
    // A load takes precedence if both decode flags are set.
    assign do_store = is_store & ~is_load;

    // Decode legality, alignment and store lane steering of the incoming request.
    always_comb begin
        f3_legal        = 1'b0;
        addr_misaligned = 1'b0;
        wdata_steer     = '0;
        wstrb_steer     = 4'b0000;

        if (is_load) begin
            f3_legal = (funct3 == F3Byte) || (funct3 == F3Half) || (funct3 == F3Word) ||
                       (funct3 == F3ByteU) || (funct3 == F3HalfU);
        end else begin
            f3_legal = (funct3 == F3Byte) || (funct3 == F3Half) || (funct3 == F3Word);
        end

        case (funct3[1:0])
            2'b01:   addr_misaligned = result_in[0];
            2'b10:   addr_misaligned = |result_in[1:0];
            default: addr_misaligned = 1'b0;
        endcase

        case (funct3[1:0])
            2'b00: begin
                wdata_steer = {4{store_data[7:0]}};
                wstrb_steer = 4'b0001 << result_in[1:0];
            end
            2'b01: begin
                wdata_steer = {2{store_data[15:0]}};
                wstrb_steer = result_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_steer = store_data;
                wstrb_steer = 4'b1111;
            end
        endcase
    end

    // Select and extend the addressed lane of the returned read data.
    always_comb begin
        load_byte  = 8'h00;
        load_half  = 16'h0000;
        load_value = mem_rdata;

        case (addr_lo_q)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            F3Byte:  load_value = {{24{load_byte[7]}}, load_byte};
            F3Half:  load_value = {{16{load_half[15]}}, load_half};
            F3ByteU: load_value = {24'h000000, load_byte};
            F3HalfU: load_value = {16'h0000, load_half};
            default: load_value = mem_rdata;
        endcase
    end

    // Next-state and output logic; everything holds unless a transition updates it.
    always_comb begin
        state_d      = state_q;
        completed_d  = 1'b0;
        result_d     = result_q;
        rd_d         = rd_q;
        misaligned_d = misaligned_q;
        illegal_d    = illegal_q;
        bus_error_d  = bus_error_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        timer_d      = timer_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        is_load_d    = is_load_q;

        case (state_q)
            StIdle: begin
                if (enabled) begin
                    rd_d         = rd_in;
                    funct3_d     = funct3;
                    addr_lo_d    = result_in[1:0];
                    is_load_d    = is_load;
                    misaligned_d = 1'b0;
                    illegal_d    = 1'b0;
                    bus_error_d  = 1'b0;
                    state_d      = StDone;
                    completed_d  = 1'b1;

                    if (!is_mem) begin
                        result_d = result_in;
                    end else if (!f3_legal) begin
                        illegal_d = 1'b1;
                        result_d  = '0;
                    end else if (addr_misaligned) begin
                        misaligned_d = 1'b1;
                        result_d     = '0;
                    end else begin
                        state_d     = StReq;
                        completed_d = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = do_store;
                        mem_addr_d  = {result_in[31:2], 2'b00};
                        mem_wdata_d = do_store ? wdata_steer : '0;
                        mem_wstrb_d = do_store ? wstrb_steer : 4'b0000;
                        timer_d     = '0;
                    end
                end
            end

            StReq: begin
                if (mem_ack) begin
                    // Ack beats a timeout expiring on the same cycle.
                    mem_req_d   = 1'b0;
                    state_d     = StDone;
                    completed_d = 1'b1;
                    result_d    = is_load_q ? load_value : '0;
                end else if (TimeoutEn && (timer_q == TimerLast)) begin
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    result_d    = '0;
                    state_d     = StDone;
                    completed_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            completed_q  <= 1'b0;
            result_q     <= '0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            bus_error_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'b0000;
            timer_q      <= '0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            is_load_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            completed_q  <= completed_d;
            result_q     <= result_d;
            rd_q         <= rd_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            bus_error_q  <= bus_error_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            timer_q      <= timer_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            is_load_q    <= is_load_d;
        end
    end

    assign completed  = completed_q;
    assign result_out = result_q;
    assign rd_out     = rd_q;
    assign misaligned = misaligned_q;
    assign illegal    = illegal_q;
    assign bus_error  = bus_error_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: hand-computed vector table, reset corner cases and
// random transactions checked against a behavioural model of the access rules.
module tb_mem_access;

    localparam int Timeout = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    logic        completed;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] result_in = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        misaligned;
    logic        illegal;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [7:0]  delay;  // cycles of mem_req before the bench acks
    } vec_t;

    typedef struct packed {
        logic [31:0] result;
        logic        mis;
        logic        ill;
        logic        berr;
        logic [7:0]  req_cycles;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    typedef struct packed {
        vec_t v;
        exp_t e;
    } rec_t;

    mem_access #(
        .ACK_TIMEOUT(Timeout),
        .TIMER_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enabled    (enabled),
        .completed  (completed),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .result_in  (result_in),
        .store_data (store_data),
        .rd_in      (rd_in),
        .result_out (result_out),
        .rd_out     (rd_out),
        .misaligned (misaligned),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input int delay);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata;
        v.rdata = rdata; v.rd = 5'd0; v.delay = 8'(delay);
        return v;
    endfunction

    function automatic exp_t mke(input logic [31:0] result, input logic mis, input logic ill,
                                 input logic berr, input int reqc, input logic [31:0] addr,
                                 input logic we, input logic [31:0] wdata,
                                 input logic [3:0] wstrb);
        exp_t e;
        e.result = result; e.mis = mis; e.ill = ill; e.berr = berr;
        e.req_cycles = 8'(reqc); e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb;
        return e;
    endfunction

    // Behavioural reference: derives the outcome from the RV32I access rules directly.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        int          sz;
        int          off;
        logic [31:0] mask;
        logic [31:0] val;
        e = '0;
        if (!v.ld && !v.st) begin
            e.result = v.addr;
            return e;
        end
        if (v.ld ? !(v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 > 3'd2)) begin
            e.ill = 1'b1;
            return e;
        end
        sz  = 1 << v.f3[1:0];
        off = int'(v.addr[1:0]);
        if ((off % sz) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.addr = {v.addr[31:2], 2'b00};
        e.we = v.st;
        e.req_cycles = (int'(v.delay) >= Timeout) ? 8'(Timeout) : 8'(int'(v.delay) + 1);
        if (v.st) begin
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = v.sdata[8*(i % sz) +: 8];
            e.wstrb = 4'(((1 << sz) - 1) << off);
        end
        if (int'(v.delay) >= Timeout) begin
            e.berr = 1'b1;
            return e;
        end
        if (v.ld) begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            val  = (v.rdata >> (8 * off)) & mask;
            if (!v.f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
            e.result = val;
        end
        return e;
    endfunction

    // Drives one transaction, plays the bus slave, then checks the outcome.
    task automatic apply(input vec_t v, input exp_t e, input string tag);
        int   cyc;
        int   reqc;
        logic bad;
        int   exp_lat;
        @(negedge clk);
        is_load = v.ld; is_store = v.st; funct3 = v.f3;
        result_in = v.addr; store_data = v.sdata; rd_in = v.rd;
        enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        // Scramble inputs to prove they were latched.
        result_in = $urandom; store_data = $urandom; rd_in = 5'($urandom);
        funct3 = 3'($urandom);
        cyc = 1; reqc = 0; bad = 1'b0;
        while (!completed && cyc < 30) begin
            if (mem_req) begin
                if (mem_addr !== e.addr || mem_we !== e.we || mem_wstrb !== e.wstrb ||
                    (e.we && mem_wdata !== e.wdata)) bad = 1'b1;
                mem_ack   = (reqc == int'(v.delay));
                mem_rdata = mem_ack ? v.rdata : $urandom;
                reqc++;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            cyc++;
        end
        exp_lat = (e.req_cycles == 0) ? 1 : int'(e.req_cycles) + 1;
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".req_cycles"}, reqc, {24'h0, e.req_cycles});
        check({tag, ".result"}, result_out, e.result);
        check({tag, ".flags"}, {29'h0, misaligned, illegal, bus_error},
              {29'h0, e.mis, e.ill, e.berr});
        check({tag, ".rd"}, {27'h0, rd_out}, {27'h0, v.rd});
        if (e.req_cycles != 0) check({tag, ".bus_fields"}, {31'h0, bad}, 32'h0);
        @(negedge clk);
        check({tag, ".completed_pulse"}, {31'h0, completed}, 32'h0);
    endtask

    rec_t tbl[14];

    initial begin
        vec_t v;
        exp_t e;
        int   stray;

        tbl[0]  = '{v: mkv(0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0),
                    e: mke(32'h0000_1234, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0)};
        tbl[1]  = '{v: mkv(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 3),
                    e: mke(32'hFFFF_FF80, 0, 0, 0, 4, 32'h0000_1000, 0, 32'h0, 4'h0)};
        tbl[2]  = '{v: mkv(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 0),
                    e: mke(32'h0000_8001, 0, 0, 0, 1, 32'h0000_2000, 0, 32'h0, 4'h0)};
        tbl[3]  = '{v: mkv(0, 1, 3'b000, 32'h0000_3001, 32'hAABB_CCDD, 32'h0, 1),
                    e: mke(32'h0, 0, 0, 0, 2, 32'h0000_3000, 1, 32'hDDDD_DDDD, 4'b0010)};
        tbl[4]  = '{v: mkv(0, 1, 3'b001, 32'h0000_3002, 32'hAABB_CCDD, 32'h0, 0),
                    e: mke(32'h0, 0, 0, 0, 1, 32'h0000_3000, 1, 32'hCCDD_CCDD, 4'b1100)};
        tbl[5]  = '{v: mkv(1, 0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0),
                    e: mke(32'h0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0)};
        tbl[6]  = '{v: mkv(1, 0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0),
                    e: mke(32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 4'h0)};
        tbl[7]  = '{v: mkv(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h1234_5678, 10),
                    e: mke(32'h0, 0, 0, 1, 4, 32'h0000_5000, 0, 32'h0, 4'h0)};
        tbl[8]  = '{v: mkv(1, 0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_1234, 2),
                    e: mke(32'hFFFF_8001, 0, 0, 0, 3, 32'h0000_6000, 0, 32'h0, 4'h0)};
        tbl[9]  = '{v: mkv(0, 1, 3'b010, 32'h0000_7000, 32'h0123_4567, 32'h0, 0),
                    e: mke(32'h0, 0, 0, 0, 1, 32'h0000_7000, 1, 32'h0123_4567, 4'b1111)};
        tbl[10] = '{v: mkv(0, 1, 3'b100, 32'h0000_7000, 32'h0, 32'h0, 0),
                    e: mke(32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 4'h0)};
        tbl[11] = '{v: mkv(1, 0, 3'b100, 32'h0000_1002, 32'h0, 32'h80FF_7F00, 1),
                    e: mke(32'h0000_00FF, 0, 0, 0, 2, 32'h0000_1000, 0, 32'h0, 4'h0)};
        tbl[12] = '{v: mkv(0, 1, 3'b001, 32'h0000_3001, 32'h0, 32'h0, 0),
                    e: mke(32'h0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0)};
        tbl[13] = '{v: mkv(1, 0, 3'b010, 32'h0000_8004, 32'h0, 32'hDEAD_BEEF, 0),
                    e: mke(32'hDEAD_BEEF, 0, 0, 0, 1, 32'h0000_8004, 0, 32'h0, 4'h0)};

        // Reset state.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.result", result_out, 32'h0);
        check("rst.rd", {27'h0, rd_out}, 32'h0);
        check("rst.ctrl", {25'h0, completed, mem_req, mem_we, misaligned, illegal, bus_error,
              1'b0}, 32'h0);
        check("rst.addr", mem_addr, 32'h0);
        check("rst.wdata", mem_wdata, 32'h0);
        check("rst.wstrb", {28'h0, mem_wstrb}, 32'h0);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            v = tbl[i].v;
            v.rd = 5'(i + 3);
            apply(v, tbl[i].e, $sformatf("tbl%0d", i));
        end

        // Reset while a request is outstanding, then a stray ack.
        @(negedge clk);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; result_in = 32'h0000_9000;
        enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        check("rstreq.req_before", {31'h0, mem_req}, 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        check("rstreq.req_dropped", {31'h0, mem_req}, 32'h0);
        rstn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            if (completed || mem_req) stray++;
            @(negedge clk);
        end
        check("rstreq.stray_ack", stray, 0);
        apply(tbl[13].v, tbl[13].e, "rstreq.after");

        // Random transactions against the reference model.
        for (int n = 0; n < 80; n++) begin
            int sel;
            sel     = $urandom_range(0, 2);
            v.ld    = (sel == 1);
            v.st    = (sel == 2);
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.rd    = 5'($urandom);
            v.delay = 8'($urandom_range(0, 6));
            e = model(v);
            apply(v, e, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of execute; consumes its result (effective address or ALU value) plus decoded load/store fields, and produces the value for writeback.
- Performs RV32I loads/stores over a simple req/ack data bus:
  - byte-lane steering for stores;
  - sign/zero extension for loads;
  - misalignment and illegal-width detection;
  - bus ack timeout.
- Uses the same enabled/completed control-flag convention as the other core stages.

Parameters:
ACK_TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before bus_error; 0 disables the timeout
TIMER_WIDTH, 8, width of timeout counter; must hold ACK_TIMEOUT

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
enabled  in  1  one-cycle start pulse; inputs valid this cycle
completed  out  1  one-cycle pulse; outputs valid
is_load  in  1  instruction is LB/LH/LW/LBU/LHU
is_store  in  1  instruction is SB/SH/SW
funct3  in  3  width/sign code
result_in  in  32  execute result (effective address for load/store)
store_data  in  32  rs2 value
rd_in  in  5  destination register
result_out  out  32  writeback value
rd_out  out  5  latched rd_in
misaligned  out  1  address misaligned for access width
illegal  out  1  unsupported funct3 for load/store
bus_error  out  1  ack timeout
mem_req  out  1  bus request, level
mem_we  out  1  1 = write
mem_addr  out  32  word address ({addr[31:2],2'b00})
mem_wdata  out  32  lane-steered store data
mem_wstrb  out  4  byte enables
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion from bus

Behaviour:
- Clock clk; reset rstn, synchronous, active-low. On reset:
  - state=IDLE;
  - completed, mem_req, mem_we, misaligned, illegal and bus_error are 0;
  - mem_wstrb=0; result_out, rd_out, mem_addr and mem_wdata are 0;
  - timer=0.
- Reset mid-transaction drops mem_req at that edge. A later mem_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - enabled=1 latches all inputs and clears the three fault flags.
  - Neither is_load nor is_store: go to DONE with result_out=result_in.
  - Load/store with funct3 not in {000,001,010,100,101} (loads) or {000,001,010} (stores): DONE, illegal=1, result_out=0, no bus access.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): DONE, misaligned=1, result_out=0, no bus access.
  - Otherwise: go to REQ. Set mem_req=1, mem_we=is_store, mem_addr, mem_wdata and mem_wstrb on the same edge.
- Stores:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1] ? 1100 : 0011.
  - SW: wdata=store_data, wstrb=1111.
- Loads: mem_wstrb=0000.
- REQ:
  - mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until ack. The timer increments each cycle.
  - mem_ack=1: drop mem_req, go to DONE.
    - Loads: extract the lane selected by addr[1:0] (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word) into result_out.
    - Stores: result_out=0.
  - Timeout (ACK_TIMEOUT!=0 and timer==ACK_TIMEOUT-1 with no ack): drop mem_req, go to DONE with bus_error=1, result_out=0.
  - Ack on the same cycle as timeout expiry: ack wins.
- DONE: completed=1 for exactly one cycle, then IDLE. Outputs other than completed hold until the next enabled.
- Latency from enabled at cycle T:
  - non-memory/fault: completed at T+1;
  - memory: mem_req rises at T+1, ack at cycle A ≥ T+1, completed at A+1.
- enabled while not IDLE is ignored. mem_ack in IDLE/DONE is ignored.
- rd_out is valid for all paths. Consumers must suppress writeback for stores and faults.

Test Plan:
- Non-memory: enabled, is_load=is_store=0, result_in=0x1234 -> next cycle completed=1, result_out=0x1234, mem_req never rises.
- LB: addr=0x1003, funct3=000, mem_rdata=0x80FF_FF7F, ack 3 cycles after req -> mem_addr=0x1000, result_out=0xFFFF_FF80, completed 1 cycle after ack.
- LHU: addr=0x2002, funct3=101, mem_rdata=0x8001_0000 -> result_out=0x0000_8001.
- SB: addr=0x3001, store_data=0xAABB_CCDD -> mem_we=1, mem_wdata=0xDDDD_DDDD, mem_wstrb=0010; SH at 0x3002 -> wstrb=1100, wdata=0xCCDD_CCDD.
- Faults:
  - LW at 0x4002 -> completed at T+1, misaligned=1, no mem_req.
  - Load funct3=011 -> illegal=1.
  - ACK_TIMEOUT=4 with no ack -> mem_req high 4 cycles, then bus_error=1, completed.
- Reset while in REQ -> mem_req=0 next edge; subsequent stray mem_ack yields no completed; new enabled works normally.
